// File: rtl/reg_writeback_buffer_pkg.sv
// Shared defaults and entry layout for the register write-back buffer.
package reg_writeback_buffer_pkg;

    localparam int unsigned WB_WIDTH    = 32;
    localparam int unsigned WB_AD_WIDTH = 5;
    localparam int unsigned WB_DEPTH    = 4;

    // One pending secondary write at the default configuration
    typedef struct packed {
        logic                   live;
        logic [WB_AD_WIDTH-1:0] addr;
        logic [WB_WIDTH-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_entry_fifo.sv
// Pending-write FIFO: ring storage, pointers, occupancy and per-entry kill by address.
module wb_entry_fifo
    import reg_writeback_buffer_pkg::*;
#(
    parameter int unsigned WIDTH    = WB_WIDTH,
    parameter int unsigned AD_WIDTH = WB_AD_WIDTH,
    parameter int unsigned DEPTH    = WB_DEPTH,
    localparam int unsigned PTR_W   = $clog2(DEPTH),
    localparam int unsigned CNT_W   = PTR_W + 1
) (
    input  logic                           clk,
    input  logic                           res,
    input  logic                           i_push,
    input  logic [AD_WIDTH-1:0]            i_push_addr,
    input  logic [WIDTH-1:0]               i_push_data,
    input  logic                           i_pop,
    input  logic                           i_kill,
    input  logic [AD_WIDTH-1:0]            i_kill_addr,
    output logic                           o_head_live,
    output logic [AD_WIDTH-1:0]            o_head_addr,
    output logic [WIDTH-1:0]               o_head_data,
    output logic                           o_empty,
    output logic                           o_full,
    output logic [CNT_W-1:0]               o_count,
    output logic [DEPTH-1:0]               o_live,
    output logic [DEPTH-1:0][AD_WIDTH-1:0] o_addr
);

    typedef struct packed {
        logic                live;
        logic [AD_WIDTH-1:0] addr;
        logic [WIDTH-1:0]    data;
    } entry_t;

    entry_t [DEPTH-1:0] r_mem;
    logic   [PTR_W-1:0] r_rd;
    logic   [PTR_W-1:0] r_wr;
    logic   [CNT_W-1:0] r_cnt;

    logic w_push;
    logic w_pop;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_count = r_cnt;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    assign o_head_live = r_mem[r_rd].live;
    assign o_head_addr = r_mem[r_rd].addr;
    assign o_head_data = r_mem[r_rd].data;

    always_comb begin
        o_live = '0;
        o_addr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_live[i] = r_mem[i].live;
            o_addr[i] = r_mem[i].addr;
        end
    end

    // Kill first so an entry written on this same edge stays live
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_mem <= '0;
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i_kill && (r_mem[i].addr == i_kill_addr)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            if (w_pop) begin
                r_mem[r_rd].live <= 1'b0;
                r_rd             <= r_rd + PTR_W'(1);
            end
            if (w_push) begin
                r_mem[r_wr] <= {1'b1, i_push_addr, i_push_data};
                r_wr        <= r_wr + PTR_W'(1);
            end
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/reg_writeback_buffer.sv
// Merges single-cycle ALU writes with buffered multi-cycle results onto one register-file port.
// Optional WB_BYPASS_EN: a secondary result may write straight through when nothing is pending.
module reg_writeback_buffer
    import reg_writeback_buffer_pkg::*;
#(
    parameter int unsigned WIDTH    = WB_WIDTH,
    parameter int unsigned AD_WIDTH = WB_AD_WIDTH,
    parameter int unsigned DEPTH    = WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   alu_we,
    input  logic [AD_WIDTH-1:0]    alu_addr,
    input  logic [WIDTH-1:0]       alu_data,
    input  logic                   sec_valid,
    output logic                   sec_ready,
    input  logic [AD_WIDTH-1:0]    sec_addr,
    input  logic [WIDTH-1:0]       sec_data,
    output logic                   wb_en,
    output logic [AD_WIDTH-1:0]    wb_addr,
    output logic [WIDTH-1:0]       wb_data,
    input  logic [AD_WIDTH-1:0]    chk_addr,
    output logic                   chk_hit,
    output logic [$clog2(DEPTH):0] fifo_count
);

    logic                           w_empty;
    logic                           w_full;
    logic                           w_head_live;
    logic [AD_WIDTH-1:0]            w_head_addr;
    logic [WIDTH-1:0]               w_head_data;
    logic [DEPTH-1:0]               w_live;
    logic [DEPTH-1:0][AD_WIDTH-1:0] w_addr;
    logic                           w_pri;
    logic                           w_accept;
    logic                           w_sec_nz;
    logic                           w_bypass;
    logic                           w_push;
    logic                           w_head_wr;
    logic                           w_pop;
    logic                           w_hit;

    assign w_pri     = alu_we && (alu_addr != '0);
    assign sec_ready = !w_full;
    assign w_accept  = sec_valid && sec_ready;
    assign w_sec_nz  = (sec_addr != '0);

`ifdef WB_BYPASS_EN
    assign w_bypass = w_accept && w_sec_nz && w_empty && !alu_we;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_accept && w_sec_nz && !w_bypass;

    // Any ALU request, even to r0, owns the port; a dead head leaves regardless
    assign w_head_wr = !alu_we && !w_empty && w_head_live;
    assign w_pop     = !w_empty && (w_head_wr || !w_head_live);

    always_comb begin
        wb_en   = 1'b0;
        wb_addr = '0;
        wb_data = '0;
        if (w_pri) begin
            wb_en   = 1'b1;
            wb_addr = alu_addr;
            wb_data = alu_data;
        end else if (w_head_wr) begin
            wb_en   = 1'b1;
            wb_addr = w_head_addr;
            wb_data = w_head_data;
        end else if (w_bypass) begin
            wb_en   = 1'b1;
            wb_addr = sec_addr;
            wb_data = sec_data;
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_live[i] && (w_addr[i] == chk_addr)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign chk_hit = w_hit && (chk_addr != '0);

    wb_entry_fifo #(
        .WIDTH    (WIDTH),
        .AD_WIDTH (AD_WIDTH),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .res         (res),
        .i_push      (w_push),
        .i_push_addr (sec_addr),
        .i_push_data (sec_data),
        .i_pop       (w_pop),
        .i_kill      (w_pri),
        .i_kill_addr (alu_addr),
        .o_head_live (w_head_live),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_count     (fifo_count),
        .o_live      (w_live),
        .o_addr      (w_addr)
    );

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Scoreboard bench for reg_writeback_buffer: queue-based reference model, random and directed traffic.
module tb_reg_writeback_buffer;
    import reg_writeback_buffer_pkg::*;

    localparam int unsigned W  = WB_WIDTH;
    localparam int unsigned AW = WB_AD_WIDTH;
    localparam int unsigned D  = WB_DEPTH;

    logic                clk = 1'b0;
    logic                res;
    logic                alu_we, sec_valid, sec_ready, wb_en, chk_hit;
    logic [AW-1:0]       alu_addr, sec_addr, wb_addr, chk_addr;
    logic [W-1:0]        alu_data, sec_data, wb_data;
    logic [$clog2(D):0]  fifo_count;

    always #5 clk = ~clk;

    reg_writeback_buffer dut (
        .clk        (clk),
        .res        (res),
        .alu_we     (alu_we),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .sec_valid  (sec_valid),
        .sec_ready  (sec_ready),
        .sec_addr   (sec_addr),
        .sec_data   (sec_data),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .chk_addr   (chk_addr),
        .chk_hit    (chk_hit),
        .fifo_count (fifo_count)
    );

    typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; } wr_t;
    typedef struct { bit live; logic [AW-1:0] addr; logic [W-1:0] data; } ent_t;

    wr_t          exp_q[$];
    ent_t         mq[$];
    logic [W-1:0] model_rf[2**AW];
    logic [W-1:0] obs_rf[2**AW];
    int           n_cmp = 0;
    int           n_err = 0;
    bit           m_acc, m_byp, m_pop;

    logic          n_res, n_we, n_sv;
    logic [AW-1:0] n_wa, n_sa, n_ca;
    logic [W-1:0]  n_wd, n_sd;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
        model_rf[a] = d;
    endtask

    // Reference behaviour from the current inputs and the pending-write list
    task automatic model_eval();
        bit hit  = 1'b0;
        bit full = (mq.size() == D);
        m_acc = res && sec_valid && !full;
        foreach (mq[i]) if (mq[i].live && mq[i].addr == chk_addr && chk_addr != 0) hit = 1'b1;
        check("sec_ready", W'(sec_ready), W'(!full));
        check("fifo_count", W'(fifo_count), W'(mq.size()));
        check("chk_hit", W'(chk_hit), W'(hit));
        m_byp = 1'b0;
`ifdef WB_BYPASS_EN
        m_byp = m_acc && sec_addr != 0 && mq.size() == 0 && !alu_we;
`endif
        if (alu_we) begin
            if (alu_addr != 0) expect_wr(alu_addr, alu_data);
        end else if (mq.size() > 0 && mq[0].live) begin
            expect_wr(mq[0].addr, mq[0].data);
        end else if (m_byp) begin
            expect_wr(sec_addr, sec_data);
        end
        m_pop = res && mq.size() > 0 && (!mq[0].live || !alu_we);
    endtask

    task automatic model_update();
        ent_t e;
        if (!res) begin
            mq.delete();
            return;
        end
        if (alu_we && alu_addr != 0)
            foreach (mq[i]) if (mq[i].addr == alu_addr) mq[i].live = 1'b0;
        if (m_pop) void'(mq.pop_front());
        if (m_acc && sec_addr != 0 && !m_byp) begin
            e.live = 1'b1;
            e.addr = sec_addr;
            e.data = sec_data;
            mq.push_back(e);
        end
    endtask

    task automatic set(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic sv, input logic [AW-1:0] sa, input logic [W-1:0] sd,
                       input logic [AW-1:0] ca);
        n_we = we; n_wa = wa; n_wd = wd;
        n_sv = sv; n_sa = sa; n_sd = sd;
        n_ca = ca;
    endtask

    task automatic step();
        @(negedge clk);
        res = n_res; alu_we = n_we; alu_addr = n_wa; alu_data = n_wd;
        sec_valid = n_sv; sec_addr = n_sa; sec_data = n_sd; chk_addr = n_ca;
        #1 model_eval();
        @(posedge clk);
        model_update();
    endtask

    task automatic idle(input int n);
        set(1'b0, '0, '0, 1'b0, '0, '0, '0);
        repeat (n) step();
    endtask

    // Asynchronous reset pulse confined between two rising edges
    task automatic reset_pulse(input logic [AW-1:0] ca);
        @(negedge clk);
        alu_we = 1'b0; sec_valid = 1'b0; chk_addr = ca;
        #1 res = 1'b0;
        mq.delete();
        #1;
        check("rst_fifo_count", W'(fifo_count), '0);
        check("rst_sec_ready", W'(sec_ready), W'(1));
        check("rst_chk_hit", W'(chk_hit), '0);
        #1 res = 1'b1;
        @(posedge clk);
    endtask

    // Monitor: every DUT write is matched against the oldest expected write
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            #2;
            if (wb_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wb_unexpected: actual write addr=%0h data=%0h expected no write at %0t",
                             wb_addr, wb_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_addr", W'(wb_addr), W'(e.addr));
                    check("wb_data", wb_data, e.data);
                end
                obs_rf[wb_addr] = wb_data;
            end
        end
    end

    initial begin
        bit hold = 1'b0;
        for (int r = 0; r < 2**AW; r++) begin
            model_rf[r] = '0;
            obs_rf[r]   = '0;
        end
        res = 1'b1;
        alu_we = 1'b0; alu_addr = '0; alu_data = '0;
        sec_valid = 1'b0; sec_addr = '0; sec_data = '0; chk_addr = '0;
        #2 res = 1'b0;

        // In reset: ALU writes still pass, secondary offers are ignored
        n_res = 1'b0;
        set(1'b1, AW'(3), 32'h1234, 1'b1, AW'(6), 32'h66, AW'(6)); step();
        set(1'b0, '0, '0, 1'b1, AW'(6), 32'h66, AW'(6)); step();
        n_res = 1'b1;

        // First accept right after release, then written from the FIFO
        set(1'b0, '0, '0, 1'b1, AW'(5), 32'hA5A5A5A5, AW'(5)); step();
        set(1'b0, '0, '0, 1'b0, '0, '0, AW'(5)); step();
        idle(2);

        // Fill behind a held ALU stream, stall the fifth, then drain in order
        for (int i = 1; i <= 4; i++) begin
            set(1'b1, AW'(9), W'(32'h900 + i), 1'b1, AW'(i), W'(32'h100 + i), AW'(i)); step();
        end
        set(1'b1, AW'(9), 32'h999, 1'b1, AW'(5), 32'h105, AW'(4)); step();
        set(1'b0, '0, '0, 1'b1, AW'(5), 32'h105, AW'(1)); step();
        set(1'b0, '0, '0, 1'b1, AW'(5), 32'h105, AW'(2)); step();
        idle(6);

        // Older pending write killed by a later ALU write
        set(1'b1, AW'(9), 32'h9, 1'b1, AW'(7), 32'h11, AW'(7)); step();
        set(1'b1, AW'(7), 32'h22, 1'b0, '0, '0, AW'(7)); step();
        set(1'b0, '0, '0, 1'b0, '0, '0, AW'(7)); step();
        idle(2);

        // Same-edge ALU write and push: the push is younger and survives
        set(1'b1, AW'(3), 32'h3, 1'b1, AW'(3), 32'h33, AW'(3)); step();
        set(1'b0, '0, '0, 1'b0, '0, '0, AW'(3)); step();
        idle(2);

        // Register zero never writes from either source
        set(1'b0, '0, '0, 1'b1, '0, 32'hDEAD, '0); step();
        set(1'b1, '0, 32'hBEEF, 1'b0, '0, '0, '0); step();
        idle(2);

        // Mid-cycle reset drops pending entries
        for (int i = 1; i <= 3; i++) begin
            set(1'b1, AW'(9), W'(32'h990 + i), 1'b1, AW'(i), W'(32'h200 + i), AW'(2)); step();
        end
        reset_pulse(AW'(2));
        set(1'b0, '0, '0, 1'b0, '0, '0, AW'(2)); repeat (4) step();

        // Randomised traffic alternating ALU-heavy and drain phases
        for (int c = 0; c < 600; c++) begin
            bit busy = ((c / 40) % 2) == 0;
            if (c == 300) begin
                reset_pulse(AW'($urandom_range(0, 7)));
                hold = 1'b0;
            end
            n_we = ($urandom_range(0, 9) < (busy ? 8 : 1));
            n_wa = AW'($urandom_range(0, 7));
            n_wd = $urandom;
            if (!hold) begin
                n_sv = ($urandom_range(0, 9) < 6);
                n_sa = AW'($urandom_range(0, 7));
                n_sd = $urandom;
            end
            n_ca = AW'($urandom_range(0, 7));
            step();
            hold = n_sv && !m_acc;
        end
        idle(10);

        check("pending_writes", W'(exp_q.size()), '0);
        for (int r = 0; r < 2**AW; r++) check($sformatf("rf[%0d]", r), obs_rf[r], model_rf[r]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
